// File: rtl/sram_mem_ctrl.sv
`timescale 1ns/1ps
// Memory-stage SRAM controller: performs 32-bit loads/stores on a 16-bit SRAM
// as a low then high half-word phase, freezing the pipeline via ready.
module sram_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int          PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [16:0] wa_q;
  logic [15:0] wdata_hi_q;
  logic        wr_q;
  logic        req;
  logic [16:0] wa;

  assign req   = rd_en | wr_en;
  assign wa    = 17'((address - BASE_ADDR) >> 2);
  assign ready = (state == DONE) || ((state == IDLE) && !req);

  // Operand latches: captured only when an access is accepted
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      wa_q       <= wa;
      wdata_hi_q <= write_data[31:16];
      wr_q       <= wr_en;
    end
  end

  // SRAM pins are registered so they never follow the request inputs combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LOW;
            cnt         <= 4'd0;
            sram_addr   <= {wa, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            if (!wr_q) read_data[15:0] <= sram_dq_in;
            state       <= HIGH;
            cnt         <= 4'd0;
            sram_addr   <= {wa_q, 1'b1};
            sram_dq_out <= wdata_hi_q;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            if (!wr_q) read_data[31:16] <= sram_dq_in;
            state      <= DONE;
            cnt        <= 4'd0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
`timescale 1ns/1ps
// Testbench for sram_mem_ctrl: directed and randomized accesses checked against
// a word-level memory model and the per-cycle access timing.
module tb_sram_mem_ctrl;

  localparam int          P    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  sram_mem_ctrl #(.BASE_ADDR(BASE), .PHASE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // External SRAM: asynchronous read, write on the clock edge while strobed
  logic [15:0] sram [0:262143];
  assign sram_dq_in = sram[sram_addr];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;

  // Reference: 32-bit word memory indexed by rebased word address
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] last_read;
  logic [17:0] last_addr;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
      chk("idle_oe", 32'(sram_dq_oe), 32'd0);
      chk("idle_rdata", read_data, last_read);
      chk("idle_addr_hold", 32'(sram_addr), 32'(last_addr));
    end
  endtask

  // One access: cycle 0 is the request in IDLE, cycle 2P+1 is DONE
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input bit hold, input bit perturb);
    bit          is_wr;
    bit          hi;
    logic [16:0] w;
    is_wr = wr;
    w     = word_of(addr);
    for (int c = 0; c <= 2*P+1; c++) begin
      @(posedge clk); #1;
      if (c == 0 || hold) begin
        rd_en = rd; wr_en = wr; address = addr; write_data = wd;
      end else begin
        rd_en = 1'b0; wr_en = 1'b0;
        if (perturb) begin address = $urandom; write_data = $urandom; end
      end
      @(negedge clk);
      chk($sformatf("ready_c%0d", c), 32'(ready), 32'(c == 2*P+1));
      if (c >= 1 && c <= 2*P) begin
        hi = (c > P);
        chk($sformatf("addr_c%0d", c), 32'(sram_addr), 32'({w, hi}));
        chk($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'(!is_wr));
        chk($sformatf("oe_c%0d", c), 32'(sram_dq_oe), 32'(is_wr));
        if (is_wr)
          chk($sformatf("dq_c%0d", c), 32'(sram_dq_out), hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
      end else begin
        chk($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'd1);
        chk($sformatf("oe_c%0d", c), 32'(sram_dq_oe), 32'd0);
      end
      if (c == 2*P+1)
        chk(is_wr ? "rdata_after_store" : "rdata_load", read_data, is_wr ? last_read : ref_rd(w));
    end
    if (is_wr) ref_mem[w] = wd;
    else       last_read = ref_rd(w);
    last_addr = {w, 1'b1};
  endtask

  initial begin
    bit          r, wflag;
    logic [31:0] a, d, old;
    for (int i = 0; i < 262144; i++) sram[i] = 16'd0;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
    last_read = 32'd0; last_addr = 18'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq", 32'(sram_dq_out), 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    rst = 1'b0;
    idle_cycles(20);

    // Store then load, then a store that must not disturb read_data
    run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("sram_lo_word", 32'(sram[4]), 32'h0000BEEF);
    chk("sram_hi_word", 32'(sram[5]), 32'h0000DEAD);
    idle_cycles(2);
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b0);
    chk("load_deadbeef", read_data, 32'hDEADBEEF);
    run_access(1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 1'b0, 1'b0);
    idle_cycles(1);

    // Simultaneous request is a write; mid-access input changes ignored
    run_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, 1'b1);
    chk("sram_w0", 32'(sram[0]), 32'h00005678);
    chk("sram_w1", 32'(sram[1]), 32'h00001234);

    // Held request through DONE, immediately followed by a second access
    run_access(1'b0, 1'b1, 32'd1100, 32'hA5A55A5A, 1'b1, 1'b0);
    run_access(1'b1, 1'b0, 32'd1100, 32'h0, 1'b0, 1'b0);
    run_access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, 1'b0);
    idle_cycles(3);

    // Reset during the high phase of a store
    old = ref_rd(word_of(BASE + 32'd40));
    @(posedge clk); #1;
    wr_en = 1'b1; address = BASE + 32'd40; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("abort_we_n_c1", 32'(sram_we_n), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_rdata", read_data, 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[word_of(BASE + 32'd40)] = {old[31:16], 16'hF00D};
    last_read = 32'd0; last_addr = 18'd0;
    idle_cycles(3);
    run_access(1'b1, 1'b0, BASE + 32'd40, 32'h0, 1'b0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      r = 1'($urandom_range(0, 1));
      wflag = 1'($urandom_range(0, 1));
      if (!r && !wflag) r = 1'b1;
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d = $urandom;
      run_access(r, wflag, a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-stage controller sitting directly downstream of the ALU: it takes the ALU's LDR/STR effective address, word-aligns it and rebases it, and performs a 32-bit load or store on a 16-bit-wide external SRAM as two half-word phases. While an access is in flight it holds `ready` low so the pipeline freezes. A completed load returns a registered 32-bit word to the write-back path.

## Interface

Parameters:
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `PHASE_CYCLES`, default 2, range 1..15: clock cycles each half-word phase holds address, data and strobes.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rd_en` input 1: load request (LDR in the memory stage).
- `wr_en` input 1: store request (STR in the memory stage).
- `address` input 32: byte address, i.e. the ALU result.
- `write_data` input 32: store data.
- `read_data` output 32: last completed load word, registered.
- `ready` output 1: high means the pipeline may advance; low means freeze.
- `sram_addr` output 18: half-word address to the SRAM.
- `sram_dq_out` output 16: write data to the SRAM.
- `sram_dq_in` input 16: read data from the SRAM.
- `sram_dq_oe` output 1: drive enable for the SRAM data bus (1 = controller drives).
- `sram_we_n` output 1: active-low SRAM write strobe.

## Operation

- **Word address:** `wa = (address - BASE_ADDR) >> 2`, computed with 32-bit wrap-around subtraction. Only `wa[16:0]` is used and higher bits are discarded. `address[1:0]` is ignored.
- **Half-word mapping:** the low half-word is at `sram_addr = {wa[16:0],1'b0}` and the high half-word at `{wa[16:0],1'b1}`.
- **Request priority:** if `rd_en` and `wr_en` are both high, the access is a write.

State machine:
- **IDLE:**
  - If `wr_en | rd_en`, latch `wa`, `write_data` and the op type, clear the phase counter, and go to LOW.
  - Otherwise stay in IDLE.
- **LOW:** drive the low half-word for `PHASE_CYCLES` cycles, then go to HIGH.
  - Write: `sram_dq_out = wdata_q[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0` for all cycles of the phase.
  - Read: `sram_dq_oe = 0`, `sram_we_n = 1`. Capture `sram_dq_in` into `read_data[15:0]` at the edge ending the last cycle of the phase.
- **HIGH:** same as LOW for the upper half-word, using `wdata_q[31:16]` and `read_data[31:16]`. After `PHASE_CYCLES` cycles, go to DONE.
- **DONE:** one cycle, then go unconditionally to IDLE. A request still asserted in DONE belongs to the finishing instruction and must not restart an access.

Outputs and data:
- **ready:** combinational.
  - 1 in IDLE with no request.
  - 0 in IDLE with a request, and 0 in LOW and HIGH.
  - 1 in DONE.
- **Latched operands:** `address` and `write_data` are latched at the IDLE→LOW transition. Input changes or deassertion during LOW or HIGH are ignored and the access completes.
- **SRAM outputs outside LOW/HIGH:** `sram_we_n = 1`, `sram_dq_oe = 0`, and `sram_addr`/`sram_dq_out` hold their last values. All four are derived from registered state only, never from the inputs.
- **read_data:** holds its value until the next load completes. A store never alters it.
- **Reset:**
  - `rst` asserted at any time forces IDLE immediately and clears the counter.
  - `read_data = 0`, `sram_addr = 0`, `sram_dq_out = 0`, `sram_dq_oe = 0`, `sram_we_n = 1`.
  - `ready` then follows the IDLE rule.
  - An aborted store may have written only its low half. This is accepted.

## Timing

- Request first seen in IDLE in cycle 0.
- LOW occupies cycles 1..P and HIGH occupies cycles P+1..2P, where P = `PHASE_CYCLES`.
- DONE is cycle 2P+1, with `ready = 1` in that cycle.
- `ready` is low for exactly 2P+1 cycles per access. With P = 2: low in cycles 0–4, high in cycle 5.
- A load's `read_data` is valid in the DONE cycle, i.e. the word is fully updated at the edge entering DONE.
- Back-to-back requests: the next access is seen in IDLE in cycle 2P+2, so there is no gap beyond the DONE cycle.
- No request: `ready` stays 1 and the SRAM stays idle (`sram_we_n = 1`, `sram_dq_oe = 0`).

## Test plan

- **Reset and idle:** reset, then idle with no requests → `ready = 1`, `sram_we_n = 1`, `sram_dq_oe = 0`, `read_data = 0` across 20 cycles.
- **Store:** P = 2, store `0xDEADBEEF` at address 1032 → in cycles 1–2 `sram_addr = 4`, `dq_out = 0xBEEF`, `we_n = 0`; in cycles 3–4 `sram_addr = 5`, `dq_out = 0xDEAD`, `we_n = 0`; `ready` low in cycles 0–4 and high in cycle 5.
- **Load:** with a behavioural SRAM model, load from 1032 after the store → `read_data = 0xDEADBEEF` in the DONE cycle. A later store to 1036 leaves `read_data` unchanged.
- **Simultaneous requests and latching:** `rd_en = wr_en = 1` with `write_data = 0x12345678` at 1024 → write to `sram_addr` 0 and 1. Changing `address`/`write_data` mid-access has no effect on the SRAM signals.
- **Held request and back-to-back accesses:** request held through DONE → exactly one access, then IDLE. A new request in cycle 6 starts a second access, with `ready` low in cycles 6–10.
- **Reset mid-access:** assert `rst` in cycle 3 of a store → on the next sample `sram_we_n = 1`, `sram_dq_oe = 0`, FSM in IDLE, `read_data = 0`. Releasing reset with no request gives `ready = 1`.
